fir_coeff_loader: RTL and testbench
===================================

FIR_COEFF_LOADER -- requirements
Module: fir_coeff_loader

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  ORDER, 7, filter order; COEFF_NUM = ORDER+1 (default 8)
  COEFF_BITS, 10, coefficient precision in bits
  CNT_BITS, 3, word-counter width; equals clog2(COEFF_NUM)
REQ-002 Ports (name direction width meaning), one per line:
  clk  in  1  sole clock, rising edge
  reset  in  1  asynchronous, active-low reset
  coeff_in  in  COEFF_BITS  coefficient word, index 0 first
  coeff_valid  in  1  coeff_in valid
  coeff_last  in  1  marks final word of a load sequence
  coeff_ready  out  1  loader accepts a word this cycle
  swap_ok  in  1  FIR sample boundary; active bank may change
  k_out  out  COEFF_NUM*COEFF_BITS  active bank; k(i) at bits [i*COEFF_BITS +: COEFF_BITS]
  load_done  out  1  one-cycle pulse; new bank now active
  load_err  out  1  one-cycle pulse; sequence rejected

Function
REQ-003 A word transfers on a rising edge with coeff_valid=1 and coeff_ready=1; no other cycle changes the shadow bank or the counter.
REQ-004 States: IDLE, LOAD, PEND; reset state is IDLE.
REQ-005 IDLE: coeff_ready=1; a transfer writes shadow[0], sets cnt=1, and enters LOAD; a transfer with coeff_last=1 in IDLE is an error unless COEFF_NUM==1.
REQ-006 LOAD: coeff_ready=1; a transfer writes shadow[cnt] and increments cnt.
REQ-007 A transfer with coeff_last=1 and cnt==COEFF_NUM-1 is a valid end: LOAD -> PEND.
REQ-008 A transfer with coeff_last=1 and cnt<COEFF_NUM-1 (short) is an error; a transfer with coeff_last=0 and cnt==COEFF_NUM-1 (long) is an error.
REQ-009 On error: load_err pulses on the next cycle, cnt clears, the state returns to IDLE, and the active bank is unchanged.
REQ-010 PEND: coeff_ready=0; when swap_ok=1 is sampled, active<=shadow on that edge, load_done=1 for exactly that one following cycle, and the state returns to IDLE.
REQ-011 The bank swap and the load_done assertion are visible in the same cycle; total latency is one edge after swap_ok sampled high in PEND.
REQ-012 k_out is driven only by active-bank registers: no combinational path from coeff_in or swap_ok to k_out.
REQ-013 swap_ok in IDLE or LOAD has no effect; coeff_valid while coeff_ready=0 has no effect.
REQ-014 A back-to-back sequence can start in the cycle after load_done.
REQ-015 Coefficients are stored bit-exact; no sign extension or arithmetic.

Reset
REQ-016 Asserting reset (low) asynchronously forces: state IDLE, cnt 0, active bank 0 (k_out=0), shadow 0, load_done 0, load_err 0.
REQ-017 During reset coeff_ready=0; coeff_ready goes to 1 on the first clk edge after deassertion.
REQ-018 Reset mid-LOAD or mid-PEND discards the partial or pending bank; no load_done or load_err pulse is generated.

Structure
REQ-019 A shared fir package holds the state enumeration and the COEFF_NUM/CNT_BITS derivation, for reuse by the serial, parallel and N-serial FIR variants.
REQ-020 One sub-module, fir_coeff_bank (a COEFF_NUM x COEFF_BITS register bank with indexed write and whole-bank copy), is instantiated twice: shadow and active.

Verification
REQ-021 Load k0..k7=1..8 with last on word 7, swap_ok=1 two cycles later -> k_out fields 1..8, load_done a single pulse, load_err never asserted.
REQ-022 Load 5 words with last on word 4 -> load_err pulse, k_out unchanged (all 0 after reset), state IDLE.
REQ-023 Load 8 words with no last -> load_err pulse after word 7; next valid 8-word load of 0x3FF -> all fields 0x3FF after swap.
REQ-024 Complete a load and hold swap_ok=0 for 20 cycles -> coeff_ready=0 and k_out stable; swap_ok=1 -> swap on the next edge.
REQ-025 Assert reset after 4 words, release, then complete a load of 8..1 -> k_out fields 8..1, no spurious pulses.
REQ-026 Toggle coeff_valid randomly during a load -> only accepted transfers are counted, and the final bank matches the scoreboard.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared FIR definitions: loader state encoding and coefficient-count derivation,
// common to the serial, parallel and N-serial FIR variants.
package fir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PEND = 2'd2
    } fir_state_e;

    // Number of coefficients for a given filter order.
    function automatic int unsigned coeff_num(input int unsigned order);
        return order + 1;
    endfunction

    // Word-counter width able to index every coefficient (at least one bit).
    function automatic int unsigned cnt_bits(input int unsigned num);
        return (num <= 1) ? 1 : $clog2(num);
    endfunction

endpackage

// File: rtl/fir_coeff_bank.sv
// COEFF_NUM x COEFF_BITS coefficient register bank.
// Ports: clk/rst_n (async active-low), wr_en_i/wr_idx_i/wr_data_i indexed write,
//        copy_en_i/copy_data_i whole-bank load (wins over a write), bank_o flat contents.
module fir_coeff_bank #(
    parameter int unsigned COEFF_NUM  = 8,
    parameter int unsigned COEFF_BITS = 10,
    parameter int unsigned IDX_BITS   = 3
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            wr_en_i,
    input  logic [IDX_BITS-1:0]             wr_idx_i,
    input  logic [COEFF_BITS-1:0]           wr_data_i,
    input  logic                            copy_en_i,
    input  logic [COEFF_NUM*COEFF_BITS-1:0] copy_data_i,
    output logic [COEFF_NUM*COEFF_BITS-1:0] bank_o
);

    localparam int unsigned BANK_W = COEFF_NUM * COEFF_BITS;

    logic [BANK_W-1:0] bank_q;
    logic [BANK_W-1:0] bank_d;

    // Next bank contents: whole-bank copy, else single indexed word.
    always_comb begin
        bank_d = bank_q;
        if (copy_en_i) begin
            bank_d = copy_data_i;
        end else if (wr_en_i) begin
            for (int unsigned i = 0; i < COEFF_NUM; i++) begin
                if (32'(wr_idx_i) == i) begin
                    bank_d[i*COEFF_BITS +: COEFF_BITS] = wr_data_i;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q <= '0;
        end else begin
            bank_q <= bank_d;
        end
    end

    assign bank_o = bank_q;

endmodule

// File: rtl/fir_coeff_loader.sv
// FIR coefficient loader: collects a serial coefficient sequence into a shadow
// bank and swaps it into the active bank at a FIR sample boundary.
// Ports: clk, reset (async active-low); coeff_in/coeff_valid/coeff_last/coeff_ready
//        word stream; swap_ok sample boundary; k_out active bank (k(i) at
//        [i*COEFF_BITS +: COEFF_BITS]); load_done / load_err one-cycle pulses.
module fir_coeff_loader
    import fir_pkg::*;
#(
    parameter int unsigned ORDER      = 7,
    parameter int unsigned COEFF_BITS = 10,
    parameter int unsigned CNT_BITS   = cnt_bits(coeff_num(ORDER))
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [COEFF_BITS-1:0]                     coeff_in,
    input  logic                                      coeff_valid,
    input  logic                                      coeff_last,
    output logic                                      coeff_ready,
    input  logic                                      swap_ok,
    output logic [coeff_num(ORDER)*COEFF_BITS-1:0]    k_out,
    output logic                                      load_done,
    output logic                                      load_err
);

    localparam int unsigned COEFF_NUM = coeff_num(ORDER);
    localparam int unsigned BANK_W    = COEFF_NUM * COEFF_BITS;
    localparam logic [CNT_BITS-1:0] LAST_IDX = CNT_BITS'(COEFF_NUM - 1);

    fir_state_e          state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                ready_q, ready_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                xfer;
    logic                at_end;
    logic                wr_en;
    logic                swap;
    logic [BANK_W-1:0]   shadow_bank;
    logic [BANK_W-1:0]   active_bank;

    assign xfer   = coeff_valid & ready_q;
    assign at_end = (cnt_q == LAST_IDX);

    // Next-state and pulse logic; cnt is always 0 in IDLE, so IDLE and LOAD share
    // one transfer rule with the end-of-sequence check done against cnt.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        wr_en   = 1'b0;
        swap    = 1'b0;

        case (state_q)
            ST_IDLE, ST_LOAD: begin
                if (xfer) begin
                    wr_en = 1'b1;
                    if (coeff_last && at_end) begin
                        cnt_d   = '0;
                        state_d = ST_PEND;
                    end else if (coeff_last || at_end) begin
                        // short (last too early) or long (no last on final word)
                        cnt_d   = '0;
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = cnt_q + CNT_BITS'(1);
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_PEND: begin
                if (swap_ok) begin
                    swap    = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d != ST_PEND);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Shadow bank: filled word by word from the input stream.
    fir_coeff_bank #(
        .COEFF_NUM  (COEFF_NUM),
        .COEFF_BITS (COEFF_BITS),
        .IDX_BITS   (CNT_BITS)
    ) u_shadow (
        .clk         (clk),
        .rst_n       (reset),
        .wr_en_i     (wr_en),
        .wr_idx_i    (cnt_q),
        .wr_data_i   (coeff_in),
        .copy_en_i   (1'b0),
        .copy_data_i ({BANK_W{1'b0}}),
        .bank_o      (shadow_bank)
    );

    // Active bank: only ever loaded as a whole from the shadow bank.
    fir_coeff_bank #(
        .COEFF_NUM  (COEFF_NUM),
        .COEFF_BITS (COEFF_BITS),
        .IDX_BITS   (CNT_BITS)
    ) u_active (
        .clk         (clk),
        .rst_n       (reset),
        .wr_en_i     (1'b0),
        .wr_idx_i    ({CNT_BITS{1'b0}}),
        .wr_data_i   ({COEFF_BITS{1'b0}}),
        .copy_en_i   (swap),
        .copy_data_i (shadow_bank),
        .bank_o      (active_bank)
    );

    assign coeff_ready = ready_q;
    assign k_out       = active_bank;
    assign load_done   = done_q;
    assign load_err    = err_q;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Self-checking bench for fir_coeff_loader: directed sequences plus randomized
// traffic, checked every cycle against a queue-based reference model.
module tb_fir_coeff_loader;

    localparam int NUM = 8;
    localparam int CB  = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic [CB-1:0]     coeff_in;
    logic              coeff_valid;
    logic              coeff_last;
    logic              coeff_ready;
    logic              swap_ok;
    logic [NUM*CB-1:0] k_out;
    logic              load_done;
    logic              load_err;

    fir_coeff_loader #(
        .ORDER      (7),
        .COEFF_BITS (10),
        .CNT_BITS   (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .coeff_in    (coeff_in),
        .coeff_valid (coeff_valid),
        .coeff_last  (coeff_last),
        .coeff_ready (coeff_ready),
        .swap_ok     (swap_ok),
        .k_out       (k_out),
        .load_done   (load_done),
        .load_err    (load_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    string phase = "init";

    // Reference model: words collected so far, pending flag, active coefficients.
    logic [CB-1:0] q_m[$];
    logic [CB-1:0] act_m[NUM];
    bit            pend_m;
    bit            ready_m;
    int            done_cnt;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
        end
    endtask

    function automatic logic [NUM*CB-1:0] pack_act();
        logic [NUM*CB-1:0] r;
        for (int i = 0; i < NUM; i++) r[i*CB +: CB] = act_m[i];
        return r;
    endfunction

    // One clock: apply inputs, advance the model, check every output after the edge.
    task automatic cycle(input bit v, input bit l, input logic [CB-1:0] d, input bit s);
        bit exp_done;
        bit exp_err;
        coeff_valid = v;
        coeff_last  = l;
        coeff_in    = d;
        swap_ok     = s;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        if (v && ready_m) begin
            q_m.push_back(d);
            if (l) begin
                if (q_m.size() == NUM) pend_m = 1'b1;
                else begin exp_err = 1'b1; q_m.delete(); end
            end else if (q_m.size() == NUM) begin
                exp_err = 1'b1;
                q_m.delete();
            end
        end else if (pend_m && s) begin
            for (int i = 0; i < NUM; i++) act_m[i] = q_m[i];
            q_m.delete();
            pend_m   = 1'b0;
            exp_done = 1'b1;
            done_cnt++;
        end
        ready_m = !pend_m;
        @(posedge clk);
        #1;
        chk("coeff_ready", 128'(coeff_ready), 128'(ready_m));
        chk("load_done",   128'(load_done),   128'(exp_done));
        chk("load_err",    128'(load_err),    128'(exp_err));
        chk("k_out",       128'(k_out),       128'(pack_act()));
    endtask

    task automatic idle(input int n, input bit s);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, CB'(0), s);
    endtask

    // Asynchronous reset mid-cycle, checked while held, released on a falling edge.
    task automatic do_reset();
        reset = 1'b0;
        #2;
        q_m.delete();
        for (int i = 0; i < NUM; i++) act_m[i] = '0;
        pend_m  = 1'b0;
        ready_m = 1'b0;
        chk("rst_k_out", 128'(k_out),       128'(0));
        chk("rst_ready", 128'(coeff_ready), 128'(0));
        chk("rst_done",  128'(load_done),   128'(0));
        chk("rst_err",   128'(load_err),    128'(0));
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [CB-1:0] w;
        int            budget;
        reset       = 1'b0;
        coeff_in    = '0;
        coeff_valid = 1'b0;
        coeff_last  = 1'b0;
        swap_ok     = 1'b0;
        done_cnt    = 0;
        do_reset();
        // first edge after release raises coeff_ready
        idle(2, 1'b0);

        // short sequence: last on word 4 of 5
        phase = "short";
        for (int i = 0; i < 5; i++) cycle(1'b1, i == 4, CB'(i + 1), 1'b0);
        idle(2, 1'b1);

        // nominal load 1..8, swap two cycles later
        phase = "nominal";
        for (int i = 0; i < NUM; i++) cycle(1'b1, i == NUM - 1, CB'(i + 1), 1'b0);
        idle(2, 1'b0);
        cycle(1'b0, 1'b0, CB'(0), 1'b1);
        idle(2, 1'b1);
        chk("nominal_field0", 128'(k_out[0 +: CB]), 128'(1));
        chk("nominal_field7", 128'(k_out[7*CB +: CB]), 128'(8));

        // long sequence, then all-ones load
        phase = "long";
        for (int i = 0; i < NUM; i++) cycle(1'b1, 1'b0, CB'(20 + i), 1'b0);
        for (int i = 0; i < NUM; i++) cycle(1'b1, i == NUM - 1, CB'(10'h3FF), 1'b0);
        cycle(1'b0, 1'b0, CB'(0), 1'b1);
        chk("long_all_ones", 128'(k_out), 128'({NUM*CB{1'b1}}));

        // held pending bank: valid words ignored while swap_ok low; back-to-back after swap
        phase = "hold";
        for (int i = 0; i < NUM; i++) cycle(1'b1, i == NUM - 1, CB'($urandom_range(0, 1023)), 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, CB'($urandom_range(0, 1023)), 1'b0);
        cycle(1'b0, 1'b0, CB'(0), 1'b1);
        for (int i = 0; i < NUM; i++) cycle(1'b1, i == NUM - 1, CB'(100 + i), 1'b0);
        cycle(1'b0, 1'b0, CB'(0), 1'b1);

        // reset mid-load discards partial bank, then load 8..1
        phase = "rst_mid";
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, CB'(50 + i), 1'b0);
        do_reset();
        idle(1, 1'b0);
        for (int i = 0; i < NUM; i++) cycle(1'b1, i == NUM - 1, CB'(NUM - i), 1'b0);
        idle(1, 1'b1);
        chk("rst_mid_field0", 128'(k_out[0 +: CB]), 128'(8));
        chk("rst_mid_field7", 128'(k_out[7*CB +: CB]), 128'(1));

        // reset while pending discards the pending bank
        phase = "rst_pend";
        for (int i = 0; i < NUM; i++) cycle(1'b1, i == NUM - 1, CB'(200 + i), 1'b0);
        do_reset();
        idle(2, 1'b1);

        // random valid toggling with random swap_ok during the load
        phase = "rand_valid";
        for (int s = 0; s < 6; s++) begin
            budget = 0;
            while (!pend_m && budget < 200) begin
                w = CB'($urandom_range(0, 1023));
                cycle(1'($urandom_range(0, 1)), q_m.size() == NUM - 1,
                      w, 1'($urandom_range(0, 1)));
                budget++;
            end
            chk("rand_valid_pending", 128'(pend_m), 128'(1));
            idle(int'($urandom_range(0, 3)), 1'b0);
            cycle(1'b0, 1'b0, CB'(0), 1'b1);
        end

        // unconstrained traffic, including errors and stray swap_ok
        phase = "rand_all";
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
                  CB'($urandom_range(0, 1023)), 1'($urandom_range(0, 3) == 0));
        end
        chk("done_seen", 128'(done_cnt > 8), 128'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
